// File: rtl/fdiv_seq.sv
// fdiv_seq: multi-cycle IEEE-754 divider using restoring digit recurrence, BPC quotient bits per cycle.
// Build option: define FDIV_SEQ_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fdiv_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned BPC   = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [2:0]             flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned Q    = MAN_W + 3;
    localparam int unsigned N    = (Q + BPC - 1) / BPC;
    localparam int unsigned QB   = N * BPC;
    localparam int unsigned CW   = $clog2(N);
    localparam int unsigned RW   = MAN_W + 2;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;
`ifdef FDIV_SEQ_ROUND_EN
    localparam bit RND_EN = 1'b1;
`else
    localparam bit RND_EN = 1'b0;
`endif
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [MAN_W:0]      dvs_q, dvs_d;
    logic [QB-1:0]       quo_q, quo_d;
    logic                sgn_q, sgn_d;
    logic [EW-1:0]       exp_q, exp_d;
    logic [W-1:0]        y_q, y_d;
    logic [2:0]          flags_q, flags_d;
    logic                in_ready_q, out_valid_q;

    // Operand field decode and classification
    logic                 s1, s2, sgn_in;
    logic [EXP_W-1:0]     e1, e2;
    logic [MAN_W-1:0]     m1, m2;
    logic                 z1, z2, inf1, inf2, nan1, nan2;

    assign s1     = x1[W-1];
    assign s2     = x2[W-1];
    assign e1     = x1[W-2:MAN_W];
    assign e2     = x2[W-2:MAN_W];
    assign m1     = x1[MAN_W-1:0];
    assign m2     = x2[MAN_W-1:0];
    assign sgn_in = s1 ^ s2;
    assign z1     = (e1 == '0);
    assign z2     = (e2 == '0);
    assign inf1   = (e1 == '1) && (m1 == '0);
    assign inf2   = (e2 == '1) && (m2 == '0);
    assign nan1   = (e1 == '1) && (m1 != '0);
    assign nan2   = (e2 == '1) && (m2 != '0);

    // Special-operand results, highest priority first
    logic              spec;
    logic [W-1:0]      spec_y;
    logic [2:0]        spec_f;

    always_comb begin
        spec   = 1'b1;
        spec_y = '0;
        spec_f = '0;
        if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2)) begin
            spec_y = QNAN;
        end else if (z2 && !z1 && !inf1) begin
            spec_y = {sgn_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_f = 3'b100;
        end else if (z1 || inf2) begin
            spec_y = {sgn_in, {(W-1){1'b0}}};
        end else if (inf1) begin
            spec_y = {sgn_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    // One recurrence step of BPC bits; the first step runs on the accept edge
    logic [RW-1:0]  it_rem;
    logic [MAN_W:0] it_dvs;
    logic [QB-1:0]  it_quo;

    always_comb begin
        it_rem = (state_q == IDLE) ? RW'({1'b1, m1}) : rem_q;
        it_dvs = (state_q == IDLE) ? {1'b1, m2} : dvs_q;
        it_quo = (state_q == IDLE) ? '0 : quo_q;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (it_rem >= RW'(it_dvs)) begin
                it_rem = it_rem - RW'(it_dvs);
                it_quo = {it_quo[QB-2:0], 1'b1};
            end else begin
                it_quo = {it_quo[QB-2:0], 1'b0};
            end
            it_rem = {it_rem[RW-2:0], 1'b0};
        end
    end

    // Normalise, round and range-check the finished quotient
    logic [QB-1:0]    qs;
    logic [QB:0]      qx;
    logic [Q-1:0]     qn;
    logic [QB-Q:0]    lows;
    logic [MAN_W-1:0] mant, mant_f;
    logic [MAN_W:0]   mant_r;
    logic             g, rb, st, inc, ovf, unf;
    logic [EW-1:0]    ex;
    logic [W-1:0]     norm_y;
    logic [2:0]       norm_f;
    logic             hid_unused;

    assign hid_unused = qn[Q-1];

    always_comb begin
        qs     = quo_q[QB-1] ? quo_q : {quo_q[QB-2:0], 1'b0};
        ex     = quo_q[QB-1] ? exp_q : exp_q - EW'(1);
        qx     = {qs, 1'b0};
        qn     = qs[QB-1 -: Q];
        lows   = qx[QB-Q:0];
        mant   = qn[Q-2:2];
        g      = qn[1];
        rb     = qn[0];
        st     = (rem_q != '0) || (lows != '0);
        inc    = RND_EN && g && (rb || st || mant[0]);
        mant_r = {1'b0, mant} + (MAN_W+1)'(inc);
        mant_f = mant_r[MAN_W-1:0];
        if (mant_r[MAN_W]) begin
            mant_f = '0;
            ex     = ex + EW'(1);
        end
        ovf    = !ex[EW-1] && (ex[EW-2:0] >= (EW-1)'(EMAX));
        unf    = ex[EW-1] || (ex == '0);
        norm_f = 3'b000;
        norm_y = {sgn_q, ex[EXP_W-1:0], mant_f};
        if (ovf) begin
            norm_y = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_f = 3'b010;
        end else if (unf) begin
            norm_y = {sgn_q, {(W-1){1'b0}}};
            norm_f = 3'b001;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        exp_d   = exp_q;
        y_d     = y_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_d = sgn_in;
                    if (spec) begin
                        y_d     = spec_y;
                        flags_d = spec_f;
                        state_d = DONE;
                    end else begin
                        rem_d   = it_rem;
                        quo_d   = it_quo;
                        dvs_d   = {1'b1, m2};
                        exp_d   = EW'(e1) - EW'(e2) + EW'(BIAS);
                        cnt_d   = CW'(1);
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = it_rem;
                quo_d = it_quo;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NORM: begin
                y_d     = norm_y;
                flags_d = norm_f;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            sgn_q       <= 1'b0;
            exp_q       <= '0;
            y_q         <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            sgn_q       <= sgn_d;
            exp_q       <= exp_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed vector table, handshake corner sequences and a model-checked sweep for fdiv_seq.
module tb_fdiv_seq;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BPC   = 1;
    localparam int unsigned N     = (MAN_W + 3 + BPC - 1) / BPC;
`ifdef FDIV_SEQ_ROUND_EN
    localparam logic [31:0] THIRD     = 32'h3EAAAAAB;
    localparam logic [31:0] TWO_THIRD = 32'h3F2AAAAB;
    localparam bit          RND       = 1'b1;
`else
    localparam logic [31:0] THIRD     = 32'h3EAAAAAA;
    localparam logic [31:0] TWO_THIRD = 32'h3F2AAAAA;
    localparam bit          RND       = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        in_ready, out_valid;
    logic [31:0] y;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fdiv_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BPC(BPC)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [2:0]  f;
        bit          sp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ey,
                       input logic [2:0] ef, input bit sp);
        vec_t v;
        v.a = a; v.b = b; v.y = ey; v.f = ef; v.sp = sp;
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end
    endtask

    // Issue one op, scramble the operands after acceptance, return result and latency
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] ry, output logic [2:0] rf, output int lat);
        wait_ready();
        out_ready = 1'b1;
        x1 = a; x2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x1 = $urandom(); x2 = $urandom();
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout: got 0, expected 1");
        end
        ry = y;
        rf = flags;
    endtask

    function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, num, qf, rm, mant;
        int  e;
        logic g, st, s;
        s   = a[31] ^ b[31];
        ma  = {40'd0, 1'b1, a[22:0]};
        mb  = {40'd0, 1'b1, b[22:0]};
        num = ma << 26;
        qf  = num / mb;
        rm  = num % mb;
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (qf >= 64'd67108864) begin
            mant = qf >> 3;
            g    = qf[2];
            st   = (qf[1:0] != 2'b00) || (rm != 0);
        end else begin
            mant = qf >> 2;
            g    = qf[1];
            st   = qf[0] || (rm != 0);
            e    = e - 1;
        end
        if (RND && g && (st || mant[0])) mant = mant + 1;
        if (mant == 64'd16777216) begin
            mant = 64'd8388608;
            e    = e + 1;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {3'b001, s, 31'd0};
        return {3'b000, s, 8'(e), mant[22:0]};
    endfunction

    initial begin
        logic [31:0] ry, a, b;
        logic [2:0]  rf;
        logic [34:0] exp_r;
        int          lat, seen;

        add(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 1'b0);
        add(32'h3F800000, 32'h40400000, THIRD,        3'b000, 1'b0);
        add(32'h40000000, 32'h40400000, TWO_THIRD,    3'b000, 1'b0);
        add(32'h3F800000, 32'h00000000, 32'h7F800000, 3'b100, 1'b1);
        add(32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 1'b1);
        add(32'hBF800000, 32'h7F800000, 32'h80000000, 3'b000, 1'b1);
        add(32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b010, 1'b0);
        add(32'h00800000, 32'h4B000000, 32'h00000000, 3'b001, 1'b0);
        add(32'h7F000000, 32'h3F000000, 32'h7F800000, 3'b010, 1'b0);
        add(32'h00800000, 32'h40000000, 32'h00000000, 3'b001, 1'b0);
        add(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 1'b0);
        add(32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 1'b0);
        add(32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 1'b0);
        add(32'h3F800000, 32'hC0800000, 32'hBE800000, 3'b000, 1'b0);
        add(32'h40E00000, 32'h40000000, 32'h40600000, 3'b000, 1'b0);
        add(32'h40000000, 32'h3F000000, 32'h40800000, 3'b000, 1'b0);
        add(32'h7F800000, 32'hBF800000, 32'hFF800000, 3'b000, 1'b1);
        add(32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, 1'b1);
        add(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 1'b1);
        add(32'h3F800000, 32'h80000000, 32'hFF800000, 3'b100, 1'b1);
        add(32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 1'b1);
        add(32'h40000000, 32'h00000005, 32'h7F800000, 3'b100, 1'b1);
        add(32'h7F800000, 32'h00000000, 32'h7F800000, 3'b000, 1'b1);
        add(32'h00000000, 32'h7F800000, 32'h00000000, 3'b000, 1'b1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y",         y,              32'd0);
        check("reset_flags",     32'(flags),     32'd0);
        rstn = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, ry, rf, lat);
            check($sformatf("vec%0d_y", i),     ry,         vecs[i].y);
            check($sformatf("vec%0d_flags", i), 32'(rf),    32'(vecs[i].f));
            check($sformatf("vec%0d_lat", i),   32'(lat),   vecs[i].sp ? 32'd1 : 32'(N + 1));
        end

        // Backpressure: result held while out_ready is low
        wait_ready();
        out_ready = 1'b0;
        x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'(N + 1));
        check("bp_y0",  y,        32'h40400000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_y",         y,              32'h40400000);
            check("bp_flags",     32'(flags),     32'd0);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);

        // Reset on the 10th DIV cycle discards the op
        out_ready = 1'b1;
        x1 = 32'h3F800000; x2 = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_in_ready_busy", 32'(in_ready), 32'd0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_y",         y,              32'd0);
        check("rst_mid_flags",     32'(flags),     32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_mid_no_result", 32'(seen), 32'd0);
        run_op(32'h40C00000, 32'h40000000, ry, rf, lat);
        check("post_rst_y",   ry,       32'h40400000);
        check("post_rst_lat", 32'(lat), 32'(N + 1));

        // Sweep of normal operands against an integer-division model
        for (int k = 0; k < 150; k++) begin
            a = {1'($urandom_range(1, 0)), 8'($urandom_range(254, 1)), 23'($urandom())};
            b = {1'($urandom_range(1, 0)), 8'($urandom_range(254, 1)), 23'($urandom())};
            exp_r = ref_div(a, b);
            run_op(a, b, ry, rf, lat);
            check($sformatf("sweep%0d_y(%h/%h)", k, a, b), ry,      exp_r[31:0]);
            check($sformatf("sweep%0d_flags", k),          32'(rf), 32'(exp_r[34:32]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
